// File: rtl/rob_ret_arb.sv
// rob_ret_arb: matches KOB channel heads against bank response heads, round-robin onto one registered return port,
// and flags bank responses that sit unclaimed for STALL_MAX cycles.
module rob_ret_arb #(
    parameter int NCH       = 3,
    parameter int NB        = 4,
    parameter int BW        = $clog2(NB),
    parameter int CW        = 2,
    parameter int DW        = 128,
    parameter int STALL_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_rob_req_i,
    input  logic [NCH*BW-1:0] ch_rob_bank_id_i,
    output logic [NCH-1:0]    ch_rob_ack_o,
    input  logic [NB-1:0]     bank_rsp_valid_i,
    input  logic [NB*CW-1:0]  bank_rsp_ch_i,
    input  logic [NB*DW-1:0]  bank_rsp_data_i,
    output logic [NB-1:0]     bank_rsp_ready_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [CW-1:0]     rsp_ch_o,
    output logic [BW-1:0]     rsp_bank_o,
    output logic [DW-1:0]     rsp_data_o,
    output logic [NB-1:0]     err_orphan_o,
    input  logic              err_clr_i
);
    localparam int SW = $clog2(STALL_MAX + 1);

    logic [NCH-1:0] match;
    logic [BW-1:0]  hb [NCH];
    logic [CW-1:0]  bc [NB];
    logic [DW-1:0]  bd [NB];
    logic           slot_free, gnt_v;
    logic [CW-1:0]  gnt_c, k;
    logic [BW-1:0]  gnt_b;

    logic           rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]  rsp_ch_q, rsp_ch_d, rr_q, rr_d;
    logic [BW-1:0]  rsp_bank_q, rsp_bank_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic [NB-1:0]  err_q, err_d;
    logic [SW-1:0]  cnt_q [NB];
    logic [SW-1:0]  cnt_d [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        assign bc[b] = bank_rsp_ch_i[b*CW +: CW];
        assign bd[b] = bank_rsp_data_i[b*DW +: DW];
        // any cycle the head is present but not popped counts toward an orphan
        assign cnt_d[b] = (!bank_rsp_valid_i[b] || bank_rsp_ready_o[b]) ? '0 :
                          (cnt_q[b] == SW'(STALL_MAX)) ? cnt_q[b] : cnt_q[b] + 1'b1;
        assign err_d[b] = (cnt_q[b] == SW'(STALL_MAX)) | (err_q[b] & ~err_clr_i);
    end

    // owner ids >= NCH can never equal a channel index, so they never match
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign hb[c]    = ch_rob_bank_id_i[c*BW +: BW];
        assign match[c] = ch_rob_req_i[c] & bank_rsp_valid_i[hb[c]] & (bc[hb[c]] == CW'(c));
    end

    assign slot_free = ~rsp_valid_q | rsp_ready_i;

    always_comb begin
        gnt_v = 1'b0;
        gnt_c = '0;
        k     = '0;
        for (int i = 0; i < NCH; i++) begin
            k = CW'((32'(rr_q) + 32'(i)) % NCH);
            if (slot_free && !gnt_v && match[k]) begin
                gnt_v = 1'b1;
                gnt_c = k;
            end
        end
    end

    assign gnt_b            = hb[gnt_c];
    assign ch_rob_ack_o     = gnt_v ? NCH'(1) << gnt_c : '0;
    assign bank_rsp_ready_o = gnt_v ? NB'(1) << gnt_b : '0;

    assign rsp_valid_d = gnt_v | (rsp_valid_q & ~rsp_ready_i);
    assign rsp_ch_d    = gnt_v ? gnt_c : rsp_ch_q;
    assign rsp_bank_d  = gnt_v ? gnt_b : rsp_bank_q;
    assign rsp_data_d  = gnt_v ? bd[gnt_b] : rsp_data_q;
    assign rr_d        = gnt_v ? ((gnt_c == CW'(NCH - 1)) ? '0 : gnt_c + 1'b1) : rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_bank_q  <= '0;
            rsp_data_q  <= '0;
            rr_q        <= '0;
            err_q       <= '0;
            for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_bank_q  <= rsp_bank_d;
            rsp_data_q  <= rsp_data_d;
            rr_q        <= rr_d;
            err_q       <= err_d;
            for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_ch_o     = rsp_ch_q;
    assign rsp_bank_o   = rsp_bank_q;
    assign rsp_data_o   = rsp_data_q;
    assign err_orphan_o = err_q;
endmodule

// File: tb/tb_rob_ret_arb.sv
// tb_rob_ret_arb: directed bench for rob_ret_arb with a scoreboard of expected return beats.
module tb_rob_ret_arb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = '0;
    logic [5:0]   bid = '0;
    logic [2:0]   ack;
    logic [3:0]   bv = '0;
    logic [7:0]   bch = '0;
    logic [511:0] bdata = '0;
    logic [3:0]   rdy;
    logic         rv;
    logic         rready = 1'b1;
    logic [1:0]   rch;
    logic [1:0]   rbank;
    logic [127:0] rdata;
    logic [3:0]   err;
    logic         err_clr = 1'b0;

    typedef struct {
        logic [1:0]   ch;
        logic [1:0]   bank;
        logic [127:0] data;
    } beat_t;
    beat_t sb[$];

    int checks = 0;
    int errors = 0;

    rob_ret_arb dut (
        .clk(clk), .rst(rst),
        .ch_rob_req_i(req), .ch_rob_bank_id_i(bid), .ch_rob_ack_o(ack),
        .bank_rsp_valid_i(bv), .bank_rsp_ch_i(bch), .bank_rsp_data_i(bdata), .bank_rsp_ready_o(rdy),
        .rsp_valid_o(rv), .rsp_ready_i(rready), .rsp_ch_o(rch), .rsp_bank_o(rbank), .rsp_data_o(rdata),
        .err_orphan_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input int b);
        req[c] = 1'b1;
        bid[c*2 +: 2] = 2'(b);
    endtask

    task automatic set_bank(input int b, input int c, input logic [127:0] d);
        bv[b] = 1'b1;
        bch[b*2 +: 2] = 2'(c);
        bdata[b*128 +: 128] = d;
    endtask

    task automatic push(input int c, input int b, input logic [127:0] d);
        beat_t e;
        e.ch = 2'(c);
        e.bank = 2'(b);
        e.data = d;
        sb.push_back(e);
    endtask

    // upstream model: acked heads and popped bank heads go away at the edge
    task automatic tick();
        logic [2:0] a;
        logic [3:0] r;
        a = ack;
        r = rdy;
        @(posedge clk);
        #1;
        req = req & ~a;
        bv  = bv & ~r;
    endtask

    task automatic check_beat(input string tag);
        beat_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed_valid=%0b", tag, rv);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 128'(rv), 128'(1));
            chk({tag, "_ch"}, 128'(rch), 128'(e.ch));
            chk({tag, "_bank"}, 128'(rbank), 128'(e.bank));
            chk({tag, "_data"}, rdata, e.data);
        end
    endtask

    initial begin
        logic any_ack;
        #12;
        chk("rst_valid", 128'(rv), 128'(0));
        chk("rst_ch", 128'(rch), 128'(0));
        chk("rst_bank", 128'(rbank), 128'(0));
        chk("rst_data", rdata, 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        rst = 1'b0;
        tick();

        // single grant
        set_ch(1, 2);
        set_bank(2, 1, 128'hA5);
        #1;
        chk("t1_ack", 128'(ack), 128'(3'b010));
        chk("t1_ready", 128'(rdy), 128'(4'b0100));
        push(1, 2, 128'hA5);
        tick();
        check_beat("t1_beat");
        tick();
        chk("t1_drop", 128'(rv), 128'(0));

        // bring ptr around to 0 with a ch2 grant, then round-robin over all three
        set_ch(2, 3);
        set_bank(3, 2, 128'h33);
        #1;
        chk("t2_pre_ack", 128'(ack), 128'(3'b100));
        push(2, 3, 128'h33);
        tick();
        check_beat("t2_pre_beat");
        set_ch(0, 0); set_bank(0, 0, 128'h10);
        set_ch(1, 1); set_bank(1, 1, 128'h11);
        set_ch(2, 3); set_bank(3, 2, 128'h13);
        #1;
        chk("t2_ack0", 128'(ack), 128'(3'b001));
        chk("t2_rdy0", 128'(rdy), 128'(4'b0001));
        push(0, 0, 128'h10);
        tick();
        check_beat("t2_beat0");
        chk("t2_ack1", 128'(ack), 128'(3'b010));
        chk("t2_rdy1", 128'(rdy), 128'(4'b0010));
        push(1, 1, 128'h11);
        tick();
        check_beat("t2_beat1");
        chk("t2_ack2", 128'(ack), 128'(3'b100));
        chk("t2_rdy2", 128'(rdy), 128'(4'b1000));
        push(2, 3, 128'h13);
        tick();
        check_beat("t2_beat2");
        set_ch(0, 0); set_bank(0, 0, 128'h20);
        set_ch(1, 1); set_bank(1, 1, 128'h21);
        set_ch(2, 3); set_bank(3, 2, 128'h23);
        #1;
        chk("t2_wrap_ack", 128'(ack), 128'(3'b001));
        push(0, 0, 128'h20);
        tick();
        check_beat("t2_wrap_beat");

        // back-pressure with ch1/ch2 still waiting
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_ack", 128'(ack), 128'(0));
            chk("t3_rdy", 128'(rdy), 128'(0));
            tick();
            chk("t3_valid", 128'(rv), 128'(1));
            chk("t3_hold", rdata, 128'h20);
        end
        rready = 1'b1;
        #1;
        chk("t3_ack_rel", 128'(ack), 128'(3'b010));
        chk("t3_rdy_rel", 128'(rdy), 128'(4'b0010));
        sb.delete(0);
        push(1, 1, 128'h21);
        tick();
        check_beat("t3_beat");
        chk("t3_ack_next", 128'(ack), 128'(3'b100));
        push(2, 3, 128'h23);
        tick();
        check_beat("t3_beat2");
        tick();
        chk("t3_idle", 128'(rv), 128'(0));

        // mismatch: bank1 owned by idle ch2
        push(0, 0, 128'h0);
        sb.delete(sb.size() - 1);
        set_ch(0, 1);
        set_bank(1, 2, 128'hBB);
        #1;
        chk("t4_ack", 128'(ack), 128'(0));
        repeat (250) tick();
        chk("t4_err_early", 128'(err), 128'(0));
        repeat (10) tick();
        chk("t4_err_set", 128'(err), 128'(4'b0010));
        err_clr = 1'b1;
        tick();
        chk("t4_set_wins", 128'(err), 128'(4'b0010));
        err_clr = 1'b0;
        bv[1] = 1'b0;
        req[0] = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_cleared", 128'(err), 128'(0));

        // invalid owner id 3 on bank2, every channel pointing at it
        set_ch(0, 2); set_ch(1, 2); set_ch(2, 2);
        set_bank(2, 3, 128'hCC);
        any_ack = 1'b0;
        for (int i = 0; i < 260; i++) begin
            #1;
            any_ack = any_ack | (|ack) | (|rdy);
            tick();
        end
        chk("t5_never_granted", 128'(any_ack), 128'(0));
        chk("t5_err", 128'(err), 128'(4'b0100));
        req = '0;
        bv = '0;

        // async reset with a beat pending and an orphan flag set
        set_ch(1, 0);
        set_bank(0, 1, 128'hDD);
        #1;
        push(1, 0, 128'hDD);
        tick();
        rready = 1'b0;
        check_beat("t6_pending");
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 128'(rv), 128'(0));
        chk("t6_err_async", 128'(err), 128'(0));
        req = '0;
        bv = '0;
        rready = 1'b1;
        #2;
        rst = 1'b0;
        set_ch(0, 0); set_bank(0, 0, 128'h30);
        set_ch(1, 1); set_bank(1, 1, 128'h31);
        #1;
        chk("t6_ptr0", 128'(ack), 128'(3'b001));
        push(0, 0, 128'h30);
        tick();
        check_beat("t6_beat");
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
